// File: rtl/top_core_pkg.sv
// Shared definitions for the top_core execute datapath: widths, instruction field
// positions, flag indices and the opcode enumeration.
package top_core_pkg;

    localparam int unsigned DATA_W   = 32'd16;
    localparam int unsigned INSTR_W  = 32'd32;
    localparam int unsigned NUM_REGS = 32'd32;
    localparam int unsigned REG_AW   = 32'd5;
    localparam int unsigned FLAG_W   = 32'd4;

    localparam int unsigned OPC_HI   = 32'd31;
    localparam int unsigned OPC_LO   = 32'd27;
    localparam int unsigned RDST_HI  = 32'd26;
    localparam int unsigned RDST_LO  = 32'd22;
    localparam int unsigned RSRC1_HI = 32'd21;
    localparam int unsigned RSRC1_LO = 32'd17;
    localparam int unsigned IMM_BIT  = 32'd16;
    localparam int unsigned RSRC2_HI = 32'd15;
    localparam int unsigned RSRC2_LO = 32'd11;
    localparam int unsigned ISRC_HI  = 32'd15;
    localparam int unsigned ISRC_LO  = 32'd0;

    // flags_o = {sign, zero, overflow, carry}
    localparam int unsigned FLAG_CARRY = 32'd0;
    localparam int unsigned FLAG_OVF   = 32'd1;
    localparam int unsigned FLAG_ZERO  = 32'd2;
    localparam int unsigned FLAG_SIGN  = 32'd3;

    typedef enum logic [4:0] {
        OP_MOVSGPR = 5'd0,
        OP_MOV     = 5'd1,
        OP_ADD     = 5'd2,
        OP_SUB     = 5'd3,
        OP_MUL     = 5'd4,
        OP_ROR     = 5'd5,
        OP_AND     = 5'd6,
        OP_XOR     = 5'd7,
        OP_XNOR    = 5'd8,
        OP_NAND    = 5'd9,
        OP_NOR     = 5'd10,
        OP_NOT     = 5'd11
    } opcode_e;

endpackage

// File: rtl/top_core_alu.sv
// Combinational ALU for top_core: result, multiply high half and status flags.
// The multiplier only exists when TOP_CORE_MUL_EN is defined.
module top_core_alu
    import top_core_pkg::*;
(
    input  logic [4:0]        op_s,
    input  logic              imm_mode_s,
    input  logic [DATA_W-1:0] a_s,
    input  logic [DATA_W-1:0] b_s,
    input  logic [DATA_W-1:0] sgpr_s,
    output logic [DATA_W-1:0] result_s,
    output logic [DATA_W-1:0] mul_hi_s,
    output logic [FLAG_W-1:0] flags_s
);

    logic [DATA_W:0]   sum_s;
    logic [DATA_W:0]   diff_s;
    logic [3:0]        rot_s;
    logic              carry_s;
    logic              ovf_s;
    logic              sign_s;
    logic              zero_s;
`ifdef TOP_CORE_MUL_EN
    logic [2*DATA_W-1:0] prod_s;
    assign prod_s = {16'd0, a_s} * {16'd0, b_s};
`endif

    assign sum_s  = {1'b0, a_s} + {1'b0, b_s};
    assign diff_s = {1'b0, a_s} - {1'b0, b_s};
    assign rot_s  = b_s[3:0];

    // Opcode select plus carry/overflow, which only ADD and SUB produce
    always_comb begin
        result_s = 16'd0;
        mul_hi_s = 16'd0;
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        case (op_s)
            OP_MOVSGPR: result_s = sgpr_s;
            OP_MOV:     result_s = imm_mode_s ? b_s : a_s;
            OP_ADD: begin
                result_s = sum_s[DATA_W-1:0];
                carry_s  = sum_s[DATA_W];
                ovf_s    = (a_s[15] == b_s[15]) && (sum_s[15] != a_s[15]);
            end
            OP_SUB: begin
                result_s = diff_s[DATA_W-1:0];
                carry_s  = diff_s[DATA_W];
                ovf_s    = (a_s[15] != b_s[15]) && (diff_s[15] != a_s[15]);
            end
`ifdef TOP_CORE_MUL_EN
            OP_MUL: begin
                result_s = prod_s[DATA_W-1:0];
                mul_hi_s = prod_s[2*DATA_W-1:DATA_W];
            end
`endif
            OP_ROR:  result_s = (a_s >> rot_s) | (a_s << (5'd16 - {1'b0, rot_s}));
            OP_AND:  result_s = a_s & b_s;
            OP_XOR:  result_s = a_s ^ b_s;
            OP_XNOR: result_s = ~(a_s ^ b_s);
            OP_NAND: result_s = ~(a_s & b_s);
            OP_NOR:  result_s = ~(a_s | b_s);
            OP_NOT:  result_s = ~b_s;
            default: result_s = 16'd0;
        endcase
    end

    // Sign/zero follow the full 32-bit product for MUL, the 16-bit result otherwise
    always_comb begin
        sign_s = result_s[15];
        zero_s = (result_s == 16'd0);
`ifdef TOP_CORE_MUL_EN
        if (op_s == OP_MUL) begin
            sign_s = prod_s[31];
            zero_s = (prod_s == 32'd0);
        end else begin
            sign_s = result_s[15];
            zero_s = (result_s == 16'd0);
        end
`endif
    end

    assign flags_s = {sign_s, zero_s, ovf_s, carry_s};

endmodule

// File: rtl/top_core.sv
// Single-cycle 16-bit execute core: decode, 32x16 register file, SGPR and flags.
// Define TOP_CORE_MUL_EN to implement opcode 4 (MUL); otherwise it is illegal.
module top_core
    import top_core_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSTR_W-1:0]  ir_i,
    input  logic                ir_valid_i,
    input  logic                host_we_i,
    input  logic [REG_AW-1:0]   host_waddr_i,
    input  logic [DATA_W-1:0]   host_wdata_i,
    input  logic [REG_AW-1:0]   host_raddr_i,
    output logic [DATA_W-1:0]   host_rdata_o,
    output logic [DATA_W-1:0]   sgpr_o,
    output logic [FLAG_W-1:0]   flags_o
);

    logic [DATA_W-1:0] gpr_r [NUM_REGS];
    logic [DATA_W-1:0] sgpr_r;
    logic [FLAG_W-1:0] flags_r;

    logic [4:0]        op_s;
    logic [REG_AW-1:0] rdst_s;
    logic [REG_AW-1:0] rsrc1_s;
    logic [REG_AW-1:0] rsrc2_s;
    logic              imm_mode_s;
    logic [DATA_W-1:0] isrc_s;
    logic [DATA_W-1:0] a_s;
    logic [DATA_W-1:0] b_s;
    logic [DATA_W-1:0] alu_res_s;
    logic [DATA_W-1:0] mul_hi_s;
    logic [FLAG_W-1:0] alu_flags_s;
    logic              legal_s;
    logic              wr_en_s;

    assign op_s       = ir_i[OPC_HI:OPC_LO];
    assign rdst_s     = ir_i[RDST_HI:RDST_LO];
    assign rsrc1_s    = ir_i[RSRC1_HI:RSRC1_LO];
    assign imm_mode_s = ir_i[IMM_BIT];
    assign rsrc2_s    = ir_i[RSRC2_HI:RSRC2_LO];
    assign isrc_s     = ir_i[ISRC_HI:ISRC_LO];

    assign a_s = gpr_r[rsrc1_s];
    assign b_s = imm_mode_s ? isrc_s : gpr_r[rsrc2_s];

    // Opcodes 12..31 never write anything; MUL is legal only with the multiplier built
    always_comb begin
        legal_s = 1'b0;
        case (op_s)
            OP_MOVSGPR, OP_MOV, OP_ADD, OP_SUB, OP_ROR, OP_AND,
            OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOT: legal_s = 1'b1;
`ifdef TOP_CORE_MUL_EN
            OP_MUL:  legal_s = 1'b1;
`else
            OP_MUL:  legal_s = 1'b0;
`endif
            default: legal_s = 1'b0;
        endcase
    end

    assign wr_en_s = ir_valid_i && legal_s;

    top_core_alu u_alu (
        .op_s       (op_s),
        .imm_mode_s (imm_mode_s),
        .a_s        (a_s),
        .b_s        (b_s),
        .sgpr_s     (sgpr_r),
        .result_s   (alu_res_s),
        .mul_hi_s   (mul_hi_s),
        .flags_s    (alu_flags_s)
    );

    // Register file: host write is issued last so it overrides a same-index instruction write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_r[i] <= 16'd0;
            end
        end else begin
            if (wr_en_s) begin
                gpr_r[rdst_s] <= alu_res_s;
            end
            if (host_we_i) begin
                gpr_r[host_waddr_i] <= host_wdata_i;
            end
        end
    end

    // SGPR captures the product high half on each executed MUL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgpr_r <= 16'd0;
        end else if (wr_en_s && (op_s == OP_MUL)) begin
            sgpr_r <= mul_hi_s;
        end
    end

    // Status flags update on every executed legal opcode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 4'd0;
        end else if (wr_en_s) begin
            flags_r <= alu_flags_s;
        end
    end

    assign host_rdata_o = gpr_r[host_raddr_i];
    assign sgpr_o       = sgpr_r;
    assign flags_o      = flags_r;

endmodule

// File: tb/tb_top_core.sv
// Self-checking bench for top_core: directed scenarios plus randomized instructions
// checked against an arithmetic reference model of the instruction set.
module tb_top_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir_i = 32'd0;
    logic        ir_valid_i = 1'b0;
    logic        host_we_i = 1'b0;
    logic [4:0]  host_waddr_i = 5'd0;
    logic [15:0] host_wdata_i = 16'd0;
    logic [4:0]  host_raddr_i = 5'd0;
    logic [15:0] host_rdata_o;
    logic [15:0] sgpr_o;
    logic [3:0]  flags_o;

    int total = 0;
    int bad = 0;

    logic [15:0] m_gpr [32];
    logic [15:0] m_sgpr;
    logic [3:0]  m_flags;

    top_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_i         (ir_i),
        .ir_valid_i   (ir_valid_i),
        .host_we_i    (host_we_i),
        .host_waddr_i (host_waddr_i),
        .host_wdata_i (host_wdata_i),
        .host_raddr_i (host_raddr_i),
        .host_rdata_o (host_rdata_o),
        .sgpr_o       (sgpr_o),
        .flags_o      (flags_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_imm(int op, int rd, int rs1, int imm);
        logic [31:0] w;
        w = {op[4:0], rd[4:0], rs1[4:0], 1'b1, imm[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] mk_reg(int op, int rd, int rs1, int rs2);
        logic [31:0] w;
        w = {op[4:0], rd[4:0], rs1[4:0], 1'b0, rs2[4:0], 11'd0};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int idx, input logic [15:0] exp);
        host_raddr_i = idx[4:0];
        #1;
        chk(tag, host_rdata_o, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = 16'd0;
        m_sgpr  = 16'd0;
        m_flags = 4'd0;
    endtask

    // Instruction semantics from the ISA rules, using plain integer arithmetic
    task automatic model_exec(input logic [31:0] ir);
        int op, rd, rs1, rs2, a, b, r, c, ov, s, z, sh;
        longint p;
        bit legal;
        op  = int'(ir[31:27]);
        rd  = int'(ir[26:22]);
        rs1 = int'(ir[21:17]);
        rs2 = int'(ir[15:11]);
        a   = int'(m_gpr[rs1]);
        b   = ir[16] ? int'(ir[15:0]) : int'(m_gpr[rs2]);
        legal = (op <= 11);
`ifndef TOP_CORE_MUL_EN
        if (op == 4) legal = 1'b0;
`endif
        c = 0; ov = 0; r = 0;
        case (op)
            0: r = int'(m_sgpr);
            1: r = ir[16] ? b : a;
            2: begin
                r  = (a + b) & 32'hFFFF;
                c  = (a + b) >> 16;
                ov = (((a ^ b) & 32'h8000) == 0 && ((a ^ r) & 32'h8000) != 0) ? 1 : 0;
            end
            3: begin
                r  = (a - b) & 32'hFFFF;
                c  = (a < b) ? 1 : 0;
                ov = (((a ^ b) & 32'h8000) != 0 && ((a ^ r) & 32'h8000) != 0) ? 1 : 0;
            end
            5: begin
                sh = b % 16;
                r  = ((a >> sh) | (a << (16 - sh))) & 32'hFFFF;
            end
            6:  r = a & b;
            7:  r = a ^ b;
            8:  r = ~(a ^ b) & 32'hFFFF;
            9:  r = ~(a & b) & 32'hFFFF;
            10: r = ~(a | b) & 32'hFFFF;
            11: r = ~b & 32'hFFFF;
            default: r = 0;
        endcase
        s = (r >> 15) & 1;
        z = (r == 0) ? 1 : 0;
        if (op == 4) begin
            p = longint'(a) * longint'(b);
            r = int'(p & 64'hFFFF);
            s = int'((p >> 31) & 64'd1);
            z = (p == 0) ? 1 : 0;
            if (legal) m_sgpr = 16'((p >> 16) & 64'hFFFF);
        end
        if (legal) begin
            m_gpr[rd] = r[15:0];
            m_flags   = {s[0], z[0], ov[0], c[0]};
        end
    endtask

    task automatic host_wr(input int addr, input logic [15:0] data);
        @(negedge clk);
        host_we_i = 1'b1; host_waddr_i = addr[4:0]; host_wdata_i = data;
        @(posedge clk);
        #1;
        host_we_i = 1'b0;
        m_gpr[addr] = data;
    endtask

    // One instruction, optionally with a concurrent host write that lands after it
    task automatic exec(input logic [31:0] ir, input bit hw, input int haddr, input logic [15:0] hdata);
        @(negedge clk);
        ir_i = ir; ir_valid_i = 1'b1;
        host_we_i = hw; host_waddr_i = haddr[4:0]; host_wdata_i = hdata;
        @(posedge clk);
        #1;
        ir_valid_i = 1'b0; host_we_i = 1'b0;
        model_exec(ir);
        if (hw) m_gpr[haddr] = hdata;
    endtask

    initial begin
        int rd, rs1, op, haddr;
        bit hw;
        logic [31:0] ir;
        logic [15:0] hd;
        model_clear();

        // Reset state
        #12;
        chk("reset_flags", {12'd0, flags_o}, 16'd0);
        chk("reset_sgpr", sgpr_o, 16'd0);
        chk_reg("reset_gpr9", 9, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        for (int i = 0; i < 32; i++) host_wr(i, 16'd2);
        exec(mk_imm(2, 0, 2, 4), 1'b0, 0, 16'd0);
        chk_reg("adi_gpr0", 0, 16'd6);
        chk("adi_flags", {12'd0, flags_o}, 16'd0);
        exec(mk_imm(1, 4, 0, 55), 1'b0, 0, 16'd0);
        chk_reg("movi", 4, 16'd55);
        exec(mk_reg(1, 4, 7, 0), 1'b0, 0, 16'd0);
        chk_reg("mov_reg", 4, 16'd2);
        exec(mk_imm(6, 4, 7, 56), 1'b0, 0, 16'd0);
        chk_reg("andi", 4, 16'd0);
        chk("andi_flags", {12'd0, flags_o}, 16'h0004);
        exec(mk_imm(7, 4, 7, 56), 1'b0, 0, 16'd0);
        chk_reg("xori", 4, 16'd58);
        chk("xori_flags", {12'd0, flags_o}, 16'h0000);
        host_wr(0, 16'h8000);
        host_wr(1, 16'h0000);
        exec(mk_reg(2, 2, 0, 1), 1'b0, 0, 16'd0);
        chk_reg("add_sign", 2, 16'h8000);
        chk("add_sign_flags", {12'd0, flags_o}, 16'h0008);
        exec(mk_reg(2, 2, 1, 1), 1'b0, 0, 16'd0);
        chk("add_zero_flags", {12'd0, flags_o}, 16'h0004);
        host_wr(1, 16'h8002);
        exec(mk_reg(2, 2, 0, 1), 1'b0, 0, 16'd0);
        chk_reg("add_ovf", 2, 16'h0002);
        chk("add_ovf_flags", {12'd0, flags_o}, 16'h0003);
        exec(mk_reg(3, 3, 1, 0), 1'b0, 0, 16'd0);
        chk_reg("sub", 3, 16'h0002);
        exec(mk_imm(13, 3, 1, 16'hFFFF), 1'b0, 0, 16'd0);
        chk_reg("illegal_nowrite", 3, 16'h0002);
        host_wr(0, 16'h0100);
        exec(mk_reg(4, 5, 0, 0), 1'b0, 0, 16'd0);
`ifdef TOP_CORE_MUL_EN
        chk_reg("mul_lo", 5, 16'h0000);
        chk("mul_sgpr", sgpr_o, 16'h0001);
        chk("mul_flags", {12'd0, flags_o}, 16'h0000);
        exec(mk_reg(0, 6, 0, 0), 1'b0, 0, 16'd0);
        chk_reg("movsgpr", 6, 16'h0001);
`else
        chk_reg("mul_disabled", 5, 16'h0002);
        chk("mul_disabled_sgpr", sgpr_o, 16'h0000);
        exec(mk_reg(0, 6, 0, 0), 1'b0, 0, 16'd0);
        chk_reg("movsgpr_zero", 6, 16'h0000);
`endif
        exec(mk_imm(1, 8, 0, 16'h1234), 1'b1, 8, 16'hBEEF);
        chk_reg("host_wins", 8, 16'hBEEF);
        exec(mk_imm(1, 9, 0, 16'h1234), 1'b1, 10, 16'hCAFE);
        chk_reg("both_wr_a", 9, 16'h1234);
        chk_reg("both_wr_b", 10, 16'hCAFE);
        exec(mk_imm(5, 11, 9, 4), 1'b0, 0, 16'd0);
        chk_reg("ror4", 11, 16'h4123);

        // Randomized instructions against the reference model
        for (int i = 0; i < 32; i++) host_wr(i, 16'($urandom));
        for (int n = 0; n < 400; n++) begin
            op  = $urandom_range(0, 15);
            rd  = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            ir  = $urandom_range(0, 1) ? mk_imm(op, rd, rs1, int'($urandom))
                                       : mk_reg(op, rd, rs1, $urandom_range(0, 31));
            hw    = ($urandom_range(0, 3) == 0);
            haddr = $urandom_range(0, 1) ? rd : $urandom_range(0, 31);
            hd    = 16'($urandom);
            exec(ir, hw, haddr, hd);
            chk_reg("rand_rdst", rd, m_gpr[rd]);
            chk("rand_flags", {12'd0, flags_o}, {12'd0, m_flags});
            chk("rand_sgpr", sgpr_o, m_sgpr);
            if (hw) chk_reg("rand_host", haddr, m_gpr[haddr]);
        end
        for (int i = 0; i < 32; i++) chk_reg("rand_sweep", i, m_gpr[i]);

        // Reset mid-instruction aborts the write and clears everything at once
        host_wr(3, 16'h00AA);
        @(negedge clk);
        ir_i = mk_imm(1, 3, 0, 16'h5555); ir_valid_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        for (int i = 0; i < 32; i++) chk_reg("rst_gpr", i, 16'd0);
        chk("rst_sgpr", sgpr_o, 16'd0);
        chk("rst_flags", {12'd0, flags_o}, 16'd0);
        ir_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reg("rst_abort", 3, 16'd0);
        exec(mk_imm(2, 12, 3, 7), 1'b0, 0, 16'd0);
        chk_reg("post_rst_add", 12, 16'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
